hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It replaces single-cycle load-use stall and flush detection with counter-driven multi-cycle stalls and multi-cycle flush windows for synchronous instruction memory. It also adds x0 filtering, operand-use qualification and a data-memory wait freeze. It sits beside the IF/ID/EX pipeline registers and drives their hold and flush controls plus the PC-redirect enable.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_unit_if.sv | 42 ++++
 rtl/hazard_detect.sv | 28 ++
 rtl/hazard_ctrl_unit.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } hz_state_e;

    localparam int REG_ZERO        = 0;
    localparam int DEF_LOAD_LAT    = 1;
    localparam int DEF_FLUSH_DEPTH = 1;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle between the IF/ID/EX stages and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: mem_busy freezes the whole pipe via the hold outputs.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5
);
    logic              id_ex_mem_read;
    logic [REG_AW-1:0] id_ex_rd;
    logic [REG_AW-1:0] if_id_rs1;
    logic [REG_AW-1:0] if_id_rs2;
    logic              if_id_use_rs1;
    logic              if_id_use_rs2;
    logic              ex_branch;
    logic              ex_zero;
    logic              ex_jal;
    logic              ex_jalr;
    logic              mem_busy;

    logic              pc_hold;
    logic              if_id_hold;
    logic              id_ex_bubble;
    logic              ex_mem_hold;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              redirect;

    modport master (
        output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_use_rs1, if_id_use_rs2, ex_branch, ex_zero,
               ex_jal, ex_jalr, mem_busy,
        input  pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold,
               flush_if_id, flush_id_ex, redirect
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_use_rs1, if_id_use_rs2, ex_branch, ex_zero,
               ex_jal, ex_jalr, mem_busy,
        output pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold,
               flush_if_id, flush_id_ex, redirect
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard and control-transfer detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; callers qualify with mem_busy.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    output logic              hz,
    output logic              take
);
    // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
    assign hz = id_ex_mem_read && (id_ex_rd != REG_AW'(REG_ZERO)) &&
                ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                 (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

    assign take = (ex_branch && ex_zero) || ex_jal || ex_jalr;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Multi-cycle load-use stall / redirect flush controller; HAZARD_PERF_CNT_EN adds perf counters.
// Latency: 0 cycles to first stall/flush cycle; extension cycles come from a registered counter.
// Backpressure: mem_busy freezes pc/if_id/ex_mem, suppresses flush/redirect and the counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = DEF_LOAD_LAT,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_events
`endif
);
    hz_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic hz, take;
    logic pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold;
    logic flush_if_id, flush_id_ex, redirect;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .id_ex_mem_read (hif.id_ex_mem_read),
        .id_ex_rd       (hif.id_ex_rd),
        .if_id_rs1      (hif.if_id_rs1),
        .if_id_rs2      (hif.if_id_rs2),
        .if_id_use_rs1  (hif.if_id_use_rs1),
        .if_id_use_rs2  (hif.if_id_use_rs2),
        .ex_branch      (hif.ex_branch),
        .ex_zero        (hif.ex_zero),
        .ex_jal         (hif.ex_jal),
        .ex_jalr        (hif.ex_jalr),
        .hz             (hz),
        .take           (take)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        redirect     = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hif.mem_busy) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            ex_mem_hold = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // Wrong-path window: take/hz from these instructions are meaningless.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (take) begin
            redirect    = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if ((state_q == ST_LSTALL) || hz) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            if (state_q == ST_LSTALL) begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (LOAD_LAT > 1) begin
                state_d = ST_LSTALL;
                cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hif.pc_hold      = pc_hold;
    assign hif.if_id_hold   = if_id_hold;
    assign hif.id_ex_bubble = id_ex_bubble;
    assign hif.ex_mem_hold  = ex_mem_hold;
    assign hif.flush_if_id  = flush_if_id;
    assign hif.flush_id_ex  = flush_id_ex;
    assign hif.redirect     = redirect;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'b0, pc_hold};
        perf_flush_d = perf_flush_q + {31'b0, redirect};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_events = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LL/FD = 1/1, 3/2, 3/4) share one stimulus stream.
// Outputs are compared every cycle against a cycles-owed reference model, plus vector table and corner sequences.
module tb_hazard_ctrl_unit;

    typedef struct packed {
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       zr;
        logic       jal;
        logic       jalr;
        logic       busy;
    } in_t;

    typedef struct {
        in_t         i;
        logic [6:0]  e;
        string       nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int step_no = 0;

    logic [6:0]  out_v [3];
    logic [6:0]  last_out [3];
    int          stall_left [3];
    int          flush_left [3];
    logic [31:0] m_pstall [3];
    logic [31:0] m_pflush [3];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall [3];
    logic [31:0] perf_flush [3];
`endif

    hazard_ctrl_unit_if #(.REG_AW(5)) if_x [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign if_x[g].id_ex_mem_read = cur.ld;
        assign if_x[g].id_ex_rd       = cur.rd;
        assign if_x[g].if_id_rs1      = cur.rs1;
        assign if_x[g].if_id_rs2      = cur.rs2;
        assign if_x[g].if_id_use_rs1  = cur.u1;
        assign if_x[g].if_id_use_rs2  = cur.u2;
        assign if_x[g].ex_branch      = cur.br;
        assign if_x[g].ex_zero        = cur.zr;
        assign if_x[g].ex_jal         = cur.jal;
        assign if_x[g].ex_jalr        = cur.jalr;
        assign if_x[g].mem_busy       = cur.busy;
        assign out_v[g] = {if_x[g].pc_hold, if_x[g].if_id_hold, if_x[g].id_ex_bubble,
                           if_x[g].ex_mem_hold, if_x[g].flush_if_id, if_x[g].flush_id_ex,
                           if_x[g].redirect};

        hazard_ctrl_unit #(
            .REG_AW      (5),
            .LOAD_LAT    (g == 0 ? 1 : 3),
            .FLUSH_DEPTH (g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .CNT_W       (4)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .hif               (if_x[g])
`ifdef HAZARD_PERF_CNT_EN
            ,
            .perf_stall_cycles (perf_stall[g]),
            .perf_flush_events (perf_flush[g])
`endif
        );
    end

    function automatic int ll_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int fd_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    function automatic in_t mk(input logic ld, input int rd, input int rs1, input int rs2,
                               input logic u1, input logic u2, input logic br, input logic zr,
                               input logic jal, input logic jalr, input logic busy);
        in_t v;
        v.ld = ld; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = u1; v.u2 = u2; v.br = br; v.zr = zr;
        v.jal = jal; v.jalr = jalr; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, step_no, act, exp);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, compare all instances against the model.
    task automatic step(input in_t v, input logic r);
        logic h, tk;
        @(negedge clk);
        cur = v;
        rst = r;
        step_no++;
        #2;
        h  = v.ld && (v.rd != 0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
        tk = (v.br && v.zr) || v.jal || v.jalr;
        for (int g = 0; g < 3; g++) begin
            logic [6:0] e;
            e = '0;
`ifdef HAZARD_PERF_CNT_EN
            check($sformatf("perf_stall%0d", g), perf_stall[g], m_pstall[g]);
            check($sformatf("perf_flush%0d", g), perf_flush[g], m_pflush[g]);
`endif
            if (r) begin
                stall_left[g] = 0;
                flush_left[g] = 0;
            end else if (v.busy) begin
                e = 7'b1101000;
            end else if (flush_left[g] > 0) begin
                e = 7'b0000110;
                flush_left[g]--;
            end else if (tk) begin
                e = 7'b0000111;
                flush_left[g] = fd_of(g) - 1;
                stall_left[g] = 0;
            end else if (stall_left[g] > 0) begin
                e = 7'b1110000;
                stall_left[g]--;
            end else if (h) begin
                e = 7'b1110000;
                stall_left[g] = ll_of(g) - 1;
            end
            check($sformatf("outs%0d", g), 32'(out_v[g]), 32'(e));
            last_out[g] = out_v[g];
            if (r) begin
                m_pstall[g] = '0;
                m_pflush[g] = '0;
            end else begin
                m_pstall[g] = m_pstall[g] + 32'(e[6]);
                m_pflush[g] = m_pflush[g] + 32'(e[0]);
            end
        end
    endtask

    vec_t vecs [12];
    in_t  z, hit, br_t;
    logic [7:0] pat_a, pat_b, pat_f;
    int   cnt_h, cnt_m;

    initial begin
        for (int g = 0; g < 3; g++) begin
            stall_left[g] = 0; flush_left[g] = 0;
            m_pstall[g] = '0; m_pflush[g] = '0;
        end
        z    = '0;
        hit  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        br_t = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        vecs[0]  = '{mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0), 7'b1110000, "hit_rs1"};
        vecs[1]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 7'b0000000, "x0_load"};
        vecs[2]  = '{mk(1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "rs2_unused"};
        vecs[3]  = '{mk(1, 7, 0, 7, 0, 1, 0, 0, 0, 0, 0), 7'b1110000, "hit_rs2"};
        vecs[4]  = '{mk(0, 9, 9, 9, 1, 1, 0, 0, 0, 0, 0), 7'b0000000, "no_load"};
        vecs[5]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 7'b0000111, "br_taken"};
        vecs[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 7'b0000000, "br_not"};
        vecs[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b0000111, "jal"};
        vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 7'b0000111, "jalr"};
        vecs[9]  = '{mk(1, 5, 5, 0, 1, 0, 0, 0, 1, 0, 0), 7'b0000111, "take_over_hz"};
        vecs[10] = '{mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 1), 7'b1101000, "busy_hz"};
        vecs[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), 7'b1101000, "busy_take"};

        // Reset state
        step(z, 1'b1);
        step(z, 1'b1);
        check("reset_a", 32'(last_out[0]), 32'd0);

        // Single-cycle table on the 1/1 instance (never leaves IDLE)
        for (int k = 0; k < 12; k++) begin
            step(vecs[k].i, 1'b0);
            check(vecs[k].nm, 32'(last_out[0]), 32'(vecs[k].e));
        end

        // Load-use stall length: 1 cycle at LL=1, 3 cycles at LL=3
        step(z, 1'b1);
        pat_a = '0; pat_b = '0;
        for (int k = 0; k < 6; k++) begin
            step((k == 0) ? hit : z, 1'b0);
            pat_a = {pat_a[6:0], last_out[0][6] & last_out[0][5] & last_out[0][4]};
            pat_b = {pat_b[6:0], last_out[1][6] & last_out[1][5] & last_out[1][4]};
        end
        check("stall_ll1", 32'(pat_a), 32'b100000);
        check("stall_ll3", 32'(pat_b), 32'b111000);

        // Redirect 1 cycle, flush 2 cycles at FD=2
        step(z, 1'b1);
        pat_b = '0; pat_f = '0;
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? br_t : z, 1'b0);
            pat_b = {pat_b[6:0], last_out[1][0]};
            pat_f = {pat_f[6:0], last_out[1][2] & last_out[1][1]};
        end
        check("redir_fd2", 32'(pat_b), 32'b1000);
        check("flush_fd2", 32'(pat_f), 32'b1100);

        // mem_busy for 2 cycles mid-stall stretches LL=3 stall to 5 held cycles
        step(z, 1'b1);
        cnt_h = 0; cnt_m = 0;
        for (int k = 0; k < 8; k++) begin
            step((k == 0) ? hit : ((k == 2 || k == 3) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1) : z), 1'b0);
            cnt_h += int'(last_out[1][6]);
            cnt_m += int'(last_out[1][3]);
        end
        check("busy_pc_hold", 32'(cnt_h), 32'd5);
        check("busy_ex_mem", 32'(cnt_m), 32'd2);

        // Reset during the FD=4 flush window aborts it
        step(z, 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
        step(z, 1'b0);
        check("flush_mid", 32'(last_out[2]), 32'b0000110);
        step(z, 1'b1);
        check("rst_in_flush", 32'(last_out[2]), 32'd0);
        step(z, 1'b0);
        check("after_rst_flush", 32'(last_out[2]), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_rst", perf_stall[2], 32'd0);
        check("perf_flush_rst", perf_flush[2], 32'd0);
`endif

        // Randomised traffic, small register space for frequent hits
        for (int k = 0; k < 600; k++) begin
            in_t v;
            v.ld   = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 3));
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 9) == 0);
            v.zr   = 1'($urandom_range(0, 1));
            v.jal  = ($urandom_range(0, 19) == 0);
            v.jalr = ($urandom_range(0, 19) == 0);
            v.busy = ($urandom_range(0, 4) == 0);
            step(v, ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
